mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM (one ce/we/sel/addr/wdata/rdata set, one-cycle read latency) between the instruction-fetch port and the load/store port of the MIPS core.
- Used for the unified-memory SoC variant. Sits between the core's rom_*/ram_* buses and the single memory.
- Requesters hold a request until they get a one-cycle ack. The pipeline stalls on the missing ack.

Parameters:
- ADDR_W, 32, address width for both ports and for memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum consecutive data grants allowed while a fetch is pending. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched instruction, valid when i_ack=1
- i_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data access request
- d_we  in  1  1 = write, 0 = read
- d_sel  in  4  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  load data, valid when d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_sel  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_ce
- busy  out  1  access in flight (state WAIT)

Behaviour:
- FSM states: IDLE, WAIT. Registers: state, grant (0 = instr, 1 = data), starve counter (4 bits).
- IDLE with no request: mem_ce=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0; stay in IDLE.
- IDLE with any request: arbitrate combinationally and drive the winner onto mem_* in the same cycle.
  - mem_ce=1.
  - mem_we = d_we if data wins, else 0.
  - mem_sel = d_sel if data wins, else 4'hF.
  - Latch grant; next state WAIT.
- Priority:
  - Data wins by default (older instruction in the pipe).
  - Instruction wins when i_req=1 and starve counter == STARVE_LIMIT.
  - Instruction wins when only i_req=1.
- Starve counter:
  - +1 on each data grant while i_req=1.
  - Cleared on an instruction grant.
  - Cleared in any cycle where i_req=0.
  - Saturates at STARVE_LIMIT.
- WAIT state:
  - mem_ce=0.
  - Pulse the ack of the granted port for exactly one cycle.
  - The granted rdata output = mem_rdata (combinational pass-through). For a write, rdata is don't-care but driven to 0.
  - Return to IDLE.
  - No new access issues in WAIT, so throughput is 1 access per 2 cycles and latency is 2 cycles from request to ack.
- Non-granted ack is always 0. i_ack and d_ack are never high in the same cycle.
- Requester contract: req, addr, we, sel and wdata stay stable from assertion until the ack cycle. The request drops the cycle after ack unless another access is wanted.
- Request dropped while in WAIT: the access still completes and the ack still pulses. The requester ignores it.
- A request held high across its ack is treated as a new request in the next IDLE cycle.
- Reset (asynchronous, any state):
  - state=IDLE, grant=0, counter=0.
  - All outputs 0: i_ack, d_ack, i_rdata, d_rdata, mem_*, busy.
  - An in-flight access is abandoned without an ack.
- Addresses pass through unmodified; no alignment checks or translation.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100 → cycle 0: mem_ce=1, mem_addr=0x100, mem_we=0, mem_sel=F. Cycle 1: i_ack=1, i_rdata = memory word at 0x100, busy=1.
- Data write then read: d_req, d_we=1, d_sel=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF → mem_we=1, mem_sel=3, d_ack in the next cycle. Then a read of 0x200 → d_rdata=0x0000BEEF (with the RAM pre-initialised to 0).
- Simultaneous: i_req=1 and d_req=1 in the same cycle → data served first (d_ack at cycle 1), instruction issued at cycle 2 with i_ack at cycle 3.
- Starvation: d_req held high continuously, i_req=1, STARVE_LIMIT=4 → exactly 4 d_acks, then the 5th grant goes to the instruction port. The counter then clears and the pattern repeats.
- Mid-operation reset: assert rst during WAIT → i_ack, d_ack, mem_ce and busy go to 0 immediately without waiting for a clock edge. After release, a fresh i_req completes normally in 2 cycles.
- Dropped request: d_req deasserted during WAIT → d_ack still pulses once. No extra access issues.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port to single-port RAM arbiter (fetch port vs load/store port)
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   i_req/i_addr                  instruction fetch request (read only)
//   i_rdata/i_ack                 fetch data and one-cycle completion pulse
//   d_req/d_we/d_sel/d_addr/d_wdata  load/store request
//   d_rdata/d_ack                 load data and one-cycle completion pulse
//   mem_ce/mem_we/mem_sel/mem_addr/mem_wdata/mem_rdata  single-port RAM, 1-cycle read latency
//   busy                          access in flight
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic       grant;        // 0 = instruction port, 1 = data port
    logic       grant_nxt;
    logic       wr_q;         // granted access is a write: its rdata is forced to 0
    logic       wr_nxt;
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;
    logic       d_wins;
    logic       issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            wr_q       <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            wr_q       <= wr_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        wr_nxt     = wr_q;
        starve_nxt = starve_cnt;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 4'h0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_ack      = 1'b0;
        i_rdata    = '0;
        d_ack      = 1'b0;
        d_rdata    = '0;
        busy       = 1'b0;

        // Data goes first (it belongs to an older instruction) unless the
        // fetch has already waited through STARVE_LIMIT data grants.
        d_wins = d_req && !(i_req && (starve_cnt >= LIMIT));
        issue  = (state == IDLE) && (i_req || d_req);

        case (state)
            IDLE: begin
                if (issue) begin
                    mem_ce    = 1'b1;
                    state_nxt = WAIT;
                    grant_nxt = d_wins;
                    wr_nxt    = d_wins && d_we;
                    if (d_wins) begin
                        mem_we    = d_we;
                        mem_sel   = d_sel;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                    end else begin
                        mem_sel   = 4'hF;
                        mem_addr  = i_addr;
                    end
                end
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
                if (grant) begin
                    d_ack   = 1'b1;
                    d_rdata = wr_q ? '0 : mem_rdata;
                end else begin
                    i_ack   = 1'b1;
                    i_rdata = mem_rdata;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Counts data grants the fetch port has sat through; any cycle
        // without a fetch request forgets the history.
        if (!i_req) begin
            starve_nxt = 4'd0;
        end else if (issue) begin
            if (d_wins) begin
                starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
            end else begin
                starve_nxt = 4'd0;
            end
        end

        // Outputs must drop the moment reset rises, not at the next edge:
        // requests may still be held high while the state register is cleared.
        if (rst) begin
            mem_ce    = 1'b0;
            mem_we    = 1'b0;
            mem_sel   = 4'h0;
            mem_addr  = '0;
            mem_wdata = '0;
            i_ack     = 1'b0;
            i_rdata   = '0;
            d_ack     = 1'b0;
            d_rdata   = '0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 1-cycle RAM model
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        drop;
    } d_txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int ce_cnt = 0;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];

    logic [32:0] exp_q [$];   // {port (1 = data), expected rdata}
    logic [31:0] i_todo [$];
    d_txn_t      d_todo [$];
    logic        i_act = 1'b0;
    logic        d_act = 1'b0;
    logic        i_ack_seen = 1'b0;
    logic        d_ack_seen = 1'b0;
    d_txn_t      d_cur;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [7:0] k);
        return (k == 8'h80) ? 32'h0 : {8'hA5, k, 8'h5A, k};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
        return r;
    endfunction

    // RAM model: one-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_sel);
            else        mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic push_i(input logic [31:0] a, output logic [32:0] e);
        i_todo.push_back(a);
        e = {1'b0, shadow[a[9:2]]};
    endtask

    task automatic push_d(input logic [31:0] a, input logic we, input logic [3:0] s,
                          input logic [31:0] wd, input logic drop, output logic [32:0] e);
        d_todo.push_back('{addr: a, we: we, sel: s, wdata: wd, drop: drop});
        if (we) begin
            shadow[a[9:2]] = merge(shadow[a[9:2]], wd, s);
            e = {1'b1, 32'h0};
        end else begin
            e = {1'b1, shadow[a[9:2]]};
        end
    endtask

    // Instruction requester: holds i_req until ack, chains the next fetch immediately
    initial begin
        i_req = 1'b0;
        i_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                i_act = 1'b0;
                i_req = 1'b0;
            end else begin
                if (i_act && i_ack_seen) begin
                    i_act = 1'b0;
                    i_req = 1'b0;
                end
                if (!i_act && i_todo.size() > 0) begin
                    i_addr = i_todo.pop_front();
                    i_req  = 1'b1;
                    i_act  = 1'b1;
                end
            end
        end
    end

    // Data requester: same contract, optionally drops d_req while the access is in WAIT
    initial begin
        d_req = 1'b0; d_we = 1'b0; d_sel = 4'h0; d_addr = '0; d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                d_act = 1'b0;
                d_req = 1'b0;
            end else begin
                if (d_act && d_ack_seen) begin
                    d_act = 1'b0;
                    d_req = 1'b0;
                end else if (d_act && d_cur.drop) begin
                    d_req = 1'b0;
                end
                if (!d_act && d_todo.size() > 0) begin
                    d_cur   = d_todo.pop_front();
                    d_addr  = d_cur.addr;
                    d_we    = d_cur.we;
                    d_sel   = d_cur.sel;
                    d_wdata = d_cur.wdata;
                    d_req   = 1'b1;
                    d_act   = 1'b1;
                end
            end
        end
    end

    // Ack monitor: pops the scoreboard in completion order
    always @(negedge clk) begin
        logic [32:0] e;
        i_ack_seen = i_ack;
        d_ack_seen = d_ack;
        if (mem_ce) ce_cnt++;
        if (i_ack && d_ack) begin
            chk("ack_overlap", {30'b0, i_ack, d_ack}, 32'h1);
        end else if (i_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 32'(exp_q.size()), 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port", {31'b0, d_ack}, {31'b0, e[32]});
                chk("ack_rdata", d_ack ? d_rdata : i_rdata, e[31:0]);
                chk("busy_on_ack", {31'b0, busy}, 32'h1);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || i_act || d_act || i_todo.size() != 0 ||
                d_todo.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size() + i_todo.size() + d_todo.size()) +
                          {31'b0, i_act | d_act}, 32'h0);
        exp_q.delete();
        i_todo.delete();
        d_todo.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [32:0] e;
        int ce0;
        for (int k = 0; k < 256; k++) begin
            ram[k]    = init_word(8'(k));
            shadow[k] = init_word(8'(k));
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_ce", {31'b0, mem_ce}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only
        push_i(32'h100, e); exp_q.push_back(e);
        @(posedge clk); #2;
        chk("fetch_ce", {31'b0, mem_ce}, 32'h1);
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_we", {31'b0, mem_we}, 32'h0);
        chk("fetch_sel", {28'b0, mem_sel}, 32'hF);
        @(posedge clk); #2;
        chk("fetch_ack", {31'b0, i_ack}, 32'h1);
        chk("fetch_busy", {31'b0, busy}, 32'h1);
        chk("fetch_wait_ce", {31'b0, mem_ce}, 32'h0);
        drain();

        // Data write then read back
        push_d(32'h200, 1'b1, 4'b0011, 32'hDEADBEEF, 1'b0, e); exp_q.push_back(e);
        @(posedge clk); #2;
        chk("wr_we", {31'b0, mem_we}, 32'h1);
        chk("wr_sel", {28'b0, mem_sel}, 32'h3);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_addr", mem_addr, 32'h200);
        @(posedge clk); #2;
        chk("wr_ack", {31'b0, d_ack}, 32'h1);
        drain();
        push_d(32'h200, 1'b0, 4'hF, 32'h0, 1'b0, e); exp_q.push_back(e);
        chk("rd_model", e[31:0], 32'h0000BEEF);
        drain();

        // Simultaneous requests: data first, then fetch
        push_d(32'h208, 1'b0, 4'hF, 32'h0, 1'b0, e); exp_q.push_back(e);
        push_i(32'h10C, e); exp_q.push_back(e);
        @(posedge clk); #2;
        chk("sim_c0_addr", mem_addr, 32'h208);
        @(posedge clk); #2;
        chk("sim_c1_dack", {31'b0, d_ack}, 32'h1);
        @(posedge clk); #2;
        chk("sim_c2_ce", {31'b0, mem_ce}, 32'h1);
        chk("sim_c2_addr", mem_addr, 32'h10C);
        @(posedge clk); #2;
        chk("sim_c3_iack", {31'b0, i_ack}, 32'h1);
        drain();

        // Starvation: 4 data grants, then the fetch, pattern repeats
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                push_d(32'h300 + 32'(16 * r + 4 * k), 1'b0, 4'hF, 32'h0, 1'b0, e);
                exp_q.push_back(e);
            end
            push_i(32'h380 + 32'(4 * r), e); exp_q.push_back(e);
        end
        drain();

        // Back-to-back random data traffic
        for (int k = 0; k < 8; k++) begin
            push_d(32'h240 + 32'(4 * $urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(1, 15)), $urandom, 1'b0, e);
            exp_q.push_back(e);
        end
        drain();

        // Dropped request: ack still pulses once, no second access
        ce0 = ce_cnt;
        push_d(32'h204, 1'b0, 4'hF, 32'h0, 1'b1, e); exp_q.push_back(e);
        drain();
        repeat (3) @(negedge clk);
        chk("drop_ce_count", 32'(ce_cnt - ce0), 32'h1);

        // Reset during WAIT
        push_i(32'h110, e); exp_q.push_back(e);
        @(posedge clk); #2;
        chk("rstw_issue", {31'b0, mem_ce}, 32'h1);
        @(posedge clk); #2;
        chk("rstw_busy_pre", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstw_iack", {31'b0, i_ack}, 32'h0);
        chk("rstw_busy", {31'b0, busy}, 32'h0);
        chk("rstw_ce", {31'b0, mem_ce}, 32'h0);
        chk("rstw_irdata", i_rdata, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_i(32'h114, e); exp_q.push_back(e);
        @(posedge clk); #2;
        chk("post_rst_addr", mem_addr, 32'h114);
        @(posedge clk); #2;
        chk("post_rst_iack", {31'b0, i_ack}, 32'h1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
